// File: rtl/bus_mem_pkg.sv
// Shared types and helpers for the cpu data-bus memory responder.
package bus_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam logic BUS_WRITE = 1'b1;
  localparam logic BUS_READ  = 1'b0;

  // Wide enough for any supported byte-address width.
  localparam int unsigned IDX_W = 64;

  function automatic logic [IDX_W-1:0] word_index(input logic [IDX_W-1:0] addr,
                                                  input logic [IDX_W-1:0] base,
                                                  input int unsigned shift);
    logic [IDX_W-1:0] offset;
    offset = addr - base;
    return offset >> shift;
  endfunction

endpackage

// File: rtl/bus_mem_array.sv
// Word storage with per-word valid bits; synchronous write, registered read
// that forwards same-cycle write data and substitutes the fill pattern.
module bus_mem_array
  import bus_mem_pkg::*;
#(
  parameter int unsigned         DATA_W       = 32,
  parameter int unsigned         DEPTH_LOG2   = 8,
  parameter logic [DATA_W-1:0]   FILL_PATTERN = 32'hAAAA_AAAA
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] w_idx,
  input  logic [DATA_W-1:0]     w_data,
  input  logic                  re,
  input  logic [DEPTH_LOG2-1:0] r_idx,
  input  logic                  r_fill,
  output logic [DATA_W-1:0]     r_data
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0]  valid_q, valid_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              fwd_s;

  // Next valid vector and next read register.
  always_comb begin
    valid_d = valid_q;
    rdata_d = rdata_q;
    fwd_s   = we && (w_idx == r_idx);
    if (we) begin
      valid_d[w_idx] = 1'b1;
    end else begin
      valid_d = valid_q;
    end
    if (!re) begin
      rdata_d = rdata_q;
    end else if (r_fill) begin
      rdata_d = FILL_PATTERN;
    end else if (fwd_s) begin
      rdata_d = w_data;
    end else if (valid_q[r_idx]) begin
      rdata_d = mem_q[r_idx];
    end else begin
      rdata_d = FILL_PATTERN;
    end
  end

  // Storage contents carry no reset; the valid bits decide what is readable.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[w_idx] <= w_data;
    end
  end

  // Valid bits and read register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= {DEPTH{1'b0}};
      rdata_q <= {DATA_W{1'b0}};
    end else begin
      valid_q <= valid_d;
      rdata_q <= rdata_d;
    end
  end

  assign r_data = rdata_q;

endmodule

// File: rtl/bus_mem_model.sv
// Parametrised data-memory responder for the cpu data bus: request capture,
// programmable wait states, RDY handshake, range check, sticky ERR, counters.
module bus_mem_model
  import bus_mem_pkg::*;
#(
  parameter int unsigned       DATA_W       = 32,
  parameter int unsigned       ADDR_W       = 32,
  parameter int unsigned       DEPTH_LOG2   = 8,
  parameter logic [ADDR_W-1:0] BASE_ADDR    = 32'h0000_0000,
  parameter int unsigned       WAIT_STATES  = 0,
  parameter logic [DATA_W-1:0] FILL_PATTERN = 32'hAAAA_AAAA,
  parameter int unsigned       CNT_W        = 16
) (
  input  logic              CLK,
  input  logic              rst_n,
  input  logic              CS,
  input  logic              WR_RD,
  input  logic [ADDR_W-1:0] ADDR,
  input  logic [DATA_W-1:0] Data_BUS_WRITE,
  output logic [DATA_W-1:0] Data_BUS_READ,
  output logic              RDY,
  output logic              ERR,
  output logic [CNT_W-1:0]  RD_CNT,
  output logic [CNT_W-1:0]  WR_CNT
);

  localparam int unsigned       SHIFT      = $clog2(DATA_W / 8);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(DATA_W / 8 - 1);
  localparam logic [3:0]        WS_LOAD    = 4'(WAIT_STATES);

  state_e             state_q, state_d;
  logic [3:0]         wcnt_q, wcnt_d;
  logic               wr_q, wr_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [DATA_W-1:0]  wdata_q, wdata_d;
  logic               rdy_q, rdy_d;
  logic               err_q, err_d;
  logic [CNT_W-1:0]   rd_cnt_q, rd_cnt_d;
  logic [CNT_W-1:0]   wr_cnt_q, wr_cnt_d;

  logic               accept_s;
  logic               complete_s;
  logic               bad_s;
  logic [IDX_W-1:0]   idx_full_s;
  logic               arr_we_s;
  logic               arr_re_s;

  // Range and alignment check on the captured address.
  always_comb begin
    idx_full_s = word_index(IDX_W'(addr_q), IDX_W'(BASE_ADDR), SHIFT);
    bad_s      = (addr_q < BASE_ADDR)
              || ((idx_full_s >> DEPTH_LOG2) != {IDX_W{1'b0}})
              || ((addr_q & ALIGN_MASK) != {ADDR_W{1'b0}});
  end

  // FSM, wait counter and request capture.
  always_comb begin
    accept_s   = CS && ((state_q == IDLE) || (state_q == RESP));
    // The counter runs down to zero, so even WAIT_STATES=0 spends one cycle in WAIT.
    complete_s = (state_q == WAIT) && (wcnt_q == 4'd0);
    state_d    = state_q;
    wcnt_d     = wcnt_q;
    wr_d       = wr_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    case (state_q)
      IDLE:    state_d = accept_s ? WAIT : IDLE;
      WAIT:    state_d = complete_s ? RESP : WAIT;
      RESP:    state_d = accept_s ? WAIT : IDLE;
      default: state_d = IDLE;
    endcase
    if (accept_s) begin
      wcnt_d  = WS_LOAD;
      wr_d    = WR_RD;
      addr_d  = ADDR;
      wdata_d = Data_BUS_WRITE;
    end else if ((state_q == WAIT) && (wcnt_q != 4'd0)) begin
      wcnt_d = wcnt_q - 4'd1;
    end else begin
      wcnt_d = wcnt_q;
    end
  end

  // Completion side effects: handshake, error flag, saturating counters.
  always_comb begin
    rdy_d    = complete_s;
    err_d    = err_q | (complete_s & bad_s);
    arr_we_s = complete_s && (wr_q == BUS_WRITE) && !bad_s;
    arr_re_s = complete_s && (wr_q == BUS_READ);
    if (arr_re_s && (rd_cnt_q != {CNT_W{1'b1}})) begin
      rd_cnt_d = rd_cnt_q + CNT_W'(1);
    end else begin
      rd_cnt_d = rd_cnt_q;
    end
    if (complete_s && (wr_q == BUS_WRITE) && (wr_cnt_q != {CNT_W{1'b1}})) begin
      wr_cnt_d = wr_cnt_q + CNT_W'(1);
    end else begin
      wr_cnt_d = wr_cnt_q;
    end
  end

  // Control and output registers.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      wcnt_q   <= 4'd0;
      wr_q     <= BUS_READ;
      addr_q   <= {ADDR_W{1'b0}};
      wdata_q  <= {DATA_W{1'b0}};
      rdy_q    <= 1'b0;
      err_q    <= 1'b0;
      rd_cnt_q <= {CNT_W{1'b0}};
      wr_cnt_q <= {CNT_W{1'b0}};
    end else begin
      state_q  <= state_d;
      wcnt_q   <= wcnt_d;
      wr_q     <= wr_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdy_q    <= rdy_d;
      err_q    <= err_d;
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
    end
  end

  bus_mem_array #(
    .DATA_W       (DATA_W),
    .DEPTH_LOG2   (DEPTH_LOG2),
    .FILL_PATTERN (FILL_PATTERN)
  ) u_array (
    .clk    (CLK),
    .rst_n  (rst_n),
    .we     (arr_we_s),
    .w_idx  (idx_full_s[DEPTH_LOG2-1:0]),
    .w_data (wdata_q),
    .re     (arr_re_s),
    .r_idx  (idx_full_s[DEPTH_LOG2-1:0]),
    .r_fill (bad_s),
    .r_data (Data_BUS_READ)
  );

  assign RDY    = rdy_q;
  assign ERR    = err_q;
  assign RD_CNT = rd_cnt_q;
  assign WR_CNT = wr_cnt_q;

endmodule

// File: tb/tb_bus_mem_model.sv
// Bench for bus_mem_model: two instances (no wait states / 4-bit counters, and
// three wait states / offset base / 16 words) checked against an access-level model.
module tb_bus_mem_model;

  localparam logic [31:0] FILL = 32'hAAAA_AAAA;

  logic        CLK = 1'b0;
  logic        rst_n;
  logic        cs_a, cs_b, wr_rd;
  logic [31:0] addr, wdata;
  logic [31:0] rd_a, rd_b;
  logic        rdy_a, rdy_b, err_a, err_b;
  logic [3:0]  rc_a, wc_a;
  logic [15:0] rc_b, wc_b;

  int checks = 0;
  int errors = 0;

  // Model: per-instance constants and state.
  int unsigned ws    [2] = '{0, 3};
  longint      base  [2] = '{64'h0, 64'h1000};
  longint      depth [2] = '{256, 16};
  int unsigned cmax  [2] = '{15, 65535};
  logic [31:0] mm    [2][256];
  bit          mv    [2][256];
  int unsigned m_rc  [2];
  int unsigned m_wc  [2];
  bit          m_err [2];
  logic [31:0] m_last[2];

  always #5 CLK = ~CLK;

  bus_mem_model #(.WAIT_STATES(0), .CNT_W(4)) u_dut_a (
    .CLK(CLK), .rst_n(rst_n), .CS(cs_a), .WR_RD(wr_rd), .ADDR(addr),
    .Data_BUS_WRITE(wdata), .Data_BUS_READ(rd_a), .RDY(rdy_a), .ERR(err_a),
    .RD_CNT(rc_a), .WR_CNT(wc_a));

  bus_mem_model #(.WAIT_STATES(3), .CNT_W(16), .DEPTH_LOG2(4),
                  .BASE_ADDR(32'h0000_1000)) u_dut_b (
    .CLK(CLK), .rst_n(rst_n), .CS(cs_b), .WR_RD(wr_rd), .ADDR(addr),
    .Data_BUS_WRITE(wdata), .Data_BUS_READ(rd_b), .RDY(rdy_b), .ERR(err_b),
    .RD_CNT(rc_b), .WR_CNT(wc_b));

  function automatic logic [31:0] o_rd(input int d);  return (d == 0) ? rd_a : rd_b; endfunction
  function automatic logic        o_rdy(input int d); return (d == 0) ? rdy_a : rdy_b; endfunction
  function automatic logic        o_err(input int d); return (d == 0) ? err_a : err_b; endfunction
  function automatic logic [31:0] o_rc(input int d);  return (d == 0) ? {28'd0, rc_a} : {16'd0, rc_b}; endfunction
  function automatic logic [31:0] o_wc(input int d);  return (d == 0) ? {28'd0, wc_a} : {16'd0, wc_b}; endfunction

  function automatic bit m_bad(input int d, input logic [31:0] a);
    longint la;
    la = longint'(a);
    if (la < base[d]) return 1'b1;
    if ((la % 4) != 0) return 1'b1;
    return ((la - base[d]) / 4) >= depth[d];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_cs(input int d, input logic v);
    if (d == 0) cs_a = v; else cs_b = v;
  endtask

  task automatic m_reset();
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 256; i++) mv[d][i] = 1'b0;
      m_rc[d] = 0; m_wc[d] = 0; m_err[d] = 1'b0; m_last[d] = 32'h0;
    end
  endtask

  task automatic do_reset();
    @(negedge CLK);
    rst_n = 1'b0; cs_a = 1'b0; cs_b = 1'b0;
    @(negedge CLK);
    rst_n = 1'b1;
    m_reset();
  endtask

  task automatic chk_state(input int d, input string tag);
    chk({tag, "_rdata"}, o_rd(d), m_last[d]);
    chk({tag, "_rdcnt"}, o_rc(d), m_rc[d]);
    chk({tag, "_wrcnt"}, o_wc(d), m_wc[d]);
    chk({tag, "_err"}, {31'd0, o_err(d)}, {31'd0, m_err[d]});
  endtask

  // Call at a negedge; returns at a negedge. keep=1 leaves CS high for a back-to-back access.
  task automatic access(input int d, input logic wr, input logic [31:0] a,
                        input logic [31:0] data, input bit drop_cs, input bit keep,
                        input string tag);
    int n;
    bit got;
    longint idx;
    set_cs(d, 1'b1); wr_rd = wr; addr = a; wdata = data;
    n = 0; got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(posedge CLK); n++;
      @(negedge CLK);
      if (i == 0) begin
        wr_rd = $urandom_range(1, 0) == 1; addr = $urandom; wdata = $urandom;
        if (drop_cs) set_cs(d, 1'b0);
      end
      if (o_rdy(d)) got = 1'b1;
    end
    chk({tag, "_latency"}, got ? n : 32'd999, ws[d] + 2);
    idx = (longint'(a) - base[d]) / 4;
    if (wr) begin
      if (!m_bad(d, a)) begin mm[d][idx] = data; mv[d][idx] = 1'b1; end
      if (m_wc[d] < cmax[d]) m_wc[d]++;
    end else begin
      m_last[d] = (!m_bad(d, a) && mv[d][idx]) ? mm[d][idx] : FILL;
      if (m_rc[d] < cmax[d]) m_rc[d]++;
    end
    if (m_bad(d, a)) m_err[d] = 1'b1;
    chk_state(d, tag);
    if (!keep) begin
      set_cs(d, 1'b0);
      @(posedge CLK);
      @(negedge CLK);
      chk({tag, "_rdy_pulse"}, {31'd0, o_rdy(d)}, 32'd0);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int d, seen, kind;
    bit keep, prev_keep, wr;
    logic [31:0] a;
    rst_n = 1'b1; cs_a = 1'b0; cs_b = 1'b0; wr_rd = 1'b0; addr = 32'h0; wdata = 32'h0;
    m_reset();
    do_reset();
    for (int k = 0; k < 2; k++) begin
      chk("reset_rdy", {31'd0, o_rdy(k)}, 32'd0);
      chk_state(k, "reset");
    end

    // Never-written read, write/read-back with wait states, back-to-back write-first.
    access(0, 1'b0, 32'h14, 32'h0, 1'b0, 1'b0, "rd_unwritten");
    access(1, 1'b1, 32'h1010, 32'hDEAD_BEEF, 1'b0, 1'b0, "ws_write");
    access(1, 1'b0, 32'h1010, 32'h0, 1'b0, 1'b0, "ws_read");
    access(0, 1'b1, 32'h40, 32'h1234, 1'b0, 1'b1, "b2b_write");
    access(0, 1'b0, 32'h40, 32'h0, 1'b0, 1'b0, "b2b_read");

    // Out-of-range and misaligned accesses.
    access(0, 1'b1, 32'h0, 32'h5555_0000, 1'b0, 1'b0, "pre_write");
    access(0, 1'b0, 32'h400, 32'h0, 1'b0, 1'b0, "oor_read");
    access(0, 1'b1, 32'h2, 32'h0BAD_0BAD, 1'b0, 1'b0, "misal_write");
    access(0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, "misal_unchanged");
    access(1, 1'b0, 32'h0FFC, 32'h0, 1'b0, 1'b0, "below_base");
    access(1, 1'b0, 32'h1010, 32'h0, 1'b1, 1'b0, "cs_drop");

    // Reset in the middle of a write to word 3.
    @(negedge CLK);
    cs_b = 1'b1; wr_rd = 1'b1; addr = 32'h100C; wdata = 32'h3333_3333;
    @(posedge CLK); @(negedge CLK);
    @(posedge CLK); @(negedge CLK);
    rst_n = 1'b0; cs_b = 1'b0;
    @(negedge CLK);
    rst_n = 1'b1;
    m_reset();
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge CLK);
      if (rdy_b) seen++;
    end
    chk("midrst_no_rdy", seen, 32'd0);
    chk_state(1, "midrst");
    access(1, 1'b0, 32'h100C, 32'h0, 1'b0, 1'b0, "midrst_read");

    // Randomised traffic.
    prev_keep = 1'b0; d = 0;
    for (int t = 0; t < 60; t++) begin
      if (!prev_keep) d = $urandom_range(1, 0);
      wr = $urandom_range(1, 0) == 1;
      if ($urandom_range(4, 0) != 0) begin
        a = 32'(base[d]) + 32'(4 * $urandom_range(7, 0));
      end else begin
        kind = $urandom_range(2, 0);
        case (kind)
          0:       a = 32'(base[d] + 4 * depth[d]) + 32'(4 * $urandom_range(3, 0));
          1:       a = 32'(base[d]) + 32'(4 * $urandom_range(7, 0)) + 32'($urandom_range(3, 1));
          default: a = (d == 1) ? 32'h0000_0FF8 : 32'hFFFF_FFF0;
        endcase
      end
      keep = ($urandom_range(2, 0) == 0) && (t != 59);
      access(d, wr, a, $urandom, ($urandom_range(7, 0) == 0) && !keep, keep, "rand");
      prev_keep = keep;
    end

    // Counter saturation on the 4-bit instance.
    do_reset();
    for (int i = 0; i < 17; i++) begin
      access(0, 1'b0, 32'(4 * (i % 8)), 32'h0, 1'b0, 1'b0, "sat");
    end
    chk("sat_final", {28'd0, rc_a}, 32'h0000_000F);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
